// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the convolution engine: runs the raster pixel handshake, tracks x/y and
// qualifies KSIZE x KSIZE windows into output pixels. It carries no pixel data.
module conv_frame_ctrl #(
    parameter int XMAX_BITS = 10,
    parameter int YMAX_BITS = 10,
    parameter int KSIZE     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [XMAX_BITS-1:0] img_width,
    input  logic [YMAX_BITS-1:0] img_height,
    input  logic                 pix_in_valid,
    output logic                 pix_in_rdy,
    input  logic                 pix_out_rdy,
    output logic                 pix_out_valid,
    output logic                 pix_out_lastx,
    output logic                 pix_out_lasty,
    output logic                 lb_wr_en,
    output logic [XMAX_BITS-1:0] lb_wr_addr,
    output logic                 win_shift,
    output logic                 out_load,
    output logic                 busy,
    output logic                 cfg_err,
    output logic                 done
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

    localparam logic [XMAX_BITS-1:0] K_X    = XMAX_BITS'(KSIZE);
    localparam logic [YMAX_BITS-1:0] K_Y    = YMAX_BITS'(KSIZE);
    localparam logic [XMAX_BITS-1:0] K_X_M1 = XMAX_BITS'(KSIZE - 1);
    localparam logic [YMAX_BITS-1:0] K_Y_M1 = YMAX_BITS'(KSIZE - 1);
    localparam logic [XMAX_BITS-1:0] X_ONE  = XMAX_BITS'(1);
    localparam logic [YMAX_BITS-1:0] Y_ONE  = YMAX_BITS'(1);

    state_e               state_q, state_d;
    logic [XMAX_BITS-1:0] x_q, x_d, w_q, w_d;
    logic [YMAX_BITS-1:0] y_q, y_d, h_q, h_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 out_valid_q, out_valid_d;
    logic                 lastx_q, lastx_d;
    logic                 lasty_q, lasty_d;

    logic acc, x_last, y_last, win_ok, out_hs;

    // Compares against W-1/H-1 stay at counter width; W,H >= KSIZE in RUN, so no underflow.
    assign x_last = (x_q == w_q - X_ONE);
    assign y_last = (y_q == h_q - Y_ONE);
    assign win_ok = (x_q >= K_X_M1) && (y_q >= K_Y_M1);

    // The single output slot may only be refilled when it is empty or draining this cycle.
    assign pix_in_rdy = (state_q == ST_RUN) && (!out_valid_q || pix_out_rdy);
    assign acc        = pix_in_valid && pix_in_rdy;
    assign out_hs     = out_valid_q && pix_out_rdy;

    assign lb_wr_en      = acc;
    assign win_shift     = acc;
    assign lb_wr_addr    = x_q;
    assign out_load      = acc && win_ok;
    assign pix_out_valid = out_valid_q;
    assign pix_out_lastx = lastx_q;
    assign pix_out_lasty = lasty_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign cfg_err       = cfg_err_q;

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        w_d         = w_q;
        h_d         = h_q;
        cfg_err_d   = cfg_err_q;
        out_valid_d = out_valid_q;
        lastx_d     = lastx_q;
        lasty_d     = lasty_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_d = img_width;
                    h_d = img_height;
                    x_d = '0;
                    y_d = '0;
                    if ((img_width < K_X) || (img_height < K_Y)) begin
                        cfg_err_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        cfg_err_d = 1'b0;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (acc) begin
                    if (x_last) begin
                        x_d = '0;
                        y_d = y_q + Y_ONE;
                        if (y_last) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        x_d = x_q + X_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_hs) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load in the same cycle as a handshake replaces the slot rather than emptying it.
        if (out_load) begin
            out_valid_d = 1'b1;
            lastx_d     = x_last;
            lasty_d     = y_last;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
            lastx_d     = 1'b0;
            lasty_d     = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            lastx_q     <= 1'b0;
            lasty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            cfg_err_q   <= cfg_err_d;
            out_valid_q <= out_valid_d;
            lastx_q     <= lastx_d;
            lasty_q     <= lasty_d;
        end
    end

endmodule
